neuron_seq_ctrl: RTL

- Sequencer for one neuron datapath: MAC stage (16 × 8-bit pixel/weight products per beat) → accumulator with bias → sigmoid wrapper.
- On a start request it walks pixel and weight memories in 128-bit chunks and clears the accumulator before the first beat.
- It qualifies each accumulate beat to match the datapath pipeline latency, then captures the 8-bit sigmoid output.
- Sits between the layer-level scheduler (start/done) and the pixel/weight block RAMs plus the MAC/ACC datapath.

---
 rtl/neuron_seq_ctrl_if.sv | 26 ++
 rtl/neuron_seq_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/neuron_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the neuron sequencer,
// the layer scheduler, the pixel/weight RAMs and the MAC/ACC/sigmoid datapath.
interface neuron_seq_ctrl_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              start;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] chunk_addr;
   logic              acc_clr;
   logic              acc_en;
   logic [7:0]        sig_in;
   logic [7:0]        result;
   logic              result_valid;

   modport master (
      input  start, sig_in,
      output busy, done, rd_en, chunk_addr, acc_clr, acc_en, result, result_valid
   );

   modport slave (
      output start, sig_in,
      input  busy, done, rd_en, chunk_addr, acc_clr, acc_en, result, result_valid
   );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Single-neuron sequencer: clears the accumulator, streams N_CHUNKS RAM beats,
// qualifies accumulation after PIPE_LAT cycles and captures the sigmoid output.
module neuron_seq_ctrl #(
   parameter int unsigned N_CHUNKS = 49,
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned PIPE_LAT = 2
) (
   input  logic               clk,
   input  logic               reset,
   neuron_seq_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      FEED,
      DRAIN,
      CAPTURE,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(N_CHUNKS - 1);
   localparam logic [ADDR_W-1:0] BEAT_ONE  = ADDR_W'(1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   beat, beat_nxt;
   logic [PIPE_LAT-1:0] acc_dly, acc_dly_nxt;
   logic [7:0]          result_q, result_nxt;
   logic                valid_q, valid_nxt;

   logic rd_en;
   logic acc_clr;
   logic busy;
   logic done;
   logic last_beat;
   logic drain_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         beat     <= '0;
         acc_dly  <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         beat     <= beat_nxt;
         acc_dly  <= acc_dly_nxt;
         result_q <= result_nxt;
         valid_q  <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      beat_nxt   = beat;
      result_nxt = result_q;
      valid_nxt  = valid_q;
      rd_en      = 1'b0;
      acc_clr    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      last_beat   = (beat == LAST_BEAT);
      // DRAIN ends once only the final stage can still hold a pending beat,
      // so CAPTURE lands on the cycle right after the last acc_en.
      drain_empty = (PIPE_LAT'({acc_dly, 1'b0}) == '0);

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = CLR;
               beat_nxt  = '0;
               valid_nxt = 1'b0;
            end
         end
         CLR: begin
            busy      = 1'b1;
            acc_clr   = 1'b1;
            state_nxt = FEED;
         end
         FEED: begin
            busy  = 1'b1;
            rd_en = 1'b1;
            if (last_beat) begin
               state_nxt = DRAIN;
            end else begin
               beat_nxt = beat + BEAT_ONE;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_empty) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            busy       = 1'b1;
            result_nxt = bus.sig_in;
            valid_nxt  = 1'b1;
            state_nxt  = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      acc_dly_nxt = PIPE_LAT'({acc_dly, rd_en});
   end

   assign bus.busy         = busy;
   assign bus.done         = done;
   assign bus.rd_en        = rd_en;
   assign bus.chunk_addr   = beat;
   assign bus.acc_clr      = acc_clr;
   assign bus.acc_en       = acc_dly[PIPE_LAT-1];
   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;

endmodule
